pixel_ram_arbiter: RTL



---
 rtl/pixel_ram_pkg.sv | 17 +
 rtl/pixel_ram_arbiter_wbuf.sv | 56 +++++
 rtl/pixel_ram_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/pixel_ram_pkg.sv
// Shared pixel RAM types and constants used by the arbiter and the packet parser.
// Pure definitions: no latency or flow control lives here.
package pixel_ram_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // First byte of every pixel packet; the parser matches on the same value.
    localparam logic [7:0] PKT_HDR = 8'hF1;

endpackage

// File: rtl/pixel_ram_arbiter_wbuf.sv
// Synchronous write-buffer FIFO; a pushed word is poppable one cycle later (no bypass).
// Pushes are ignored when full and pops when empty, even if the other side moves in the same cycle.
module wbuf_fifo
    import pixel_ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_ram_arbiter.sv
// Single-port pixel RAM arbiter: reads have priority, buffered writes forced after WR_STARVE_MAX reads.
// RAM strobes are registered (grant -> access next cycle); read data returns 2 cycles after handshake.
module pixel_ram_arbiter
    import pixel_ram_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int WBUF_DEPTH    = 4,
    parameter int WR_STARVE_MAX = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              rd_valid,
    output logic                              rd_ready,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic                              rd_data_valid,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              ram_en,
    output logic                              ram_we,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_wdata,
    input  logic [DATA_W-1:0]                 ram_rdata,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_level
);

    localparam int              SC_W       = $clog2(WR_STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(WR_STARVE_MAX);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ADDR_W+DATA_W-1:0]   fifo_dout;
    logic [ADDR_W-1:0]          pop_addr;
    logic [DATA_W-1:0]          pop_wdata;
    logic                       rd_grant;
    logic                       wr_grant;
    logic [SC_W-1:0]            starve_cnt;

    assign wr_ready = ~fifo_full;
    assign rd_ready = rd_grant;
    assign rd_data  = ram_rdata;
    assign {pop_addr, pop_wdata} = fifo_dout;

    wbuf_fifo #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_valid & wr_ready),
        .push_data ({wr_addr, wr_data}),
        .pop       (wr_grant),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (wbuf_level)
    );

    always_comb begin
        rd_grant = rd_valid & (fifo_empty | (starve_cnt < STARVE_LIM));
        wr_grant = ~rd_grant & ~fifo_empty;
    end

    // Only reads that overtake waiting writes count toward starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (wr_grant) begin
            starve_cnt <= '0;
        end else if (rd_grant && !fifo_empty && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            ram_en        <= rd_grant | wr_grant;
            ram_we        <= wr_grant;
            rd_data_valid <= ram_en & ~ram_we;
            if (rd_grant) begin
                ram_addr <= rd_addr;
            end else if (wr_grant) begin
                ram_addr  <= pop_addr;
                ram_wdata <= pop_wdata;
            end
        end
    end

endmodule
